// File: rtl/fetch_pc_unit_if.sv
// fetch_pc_unit_if
//   Groups the fetch unit's pipeline-facing signals: instruction-memory
//   address/data, jump predictor inputs, IF/ID register outputs, squash and
//   performance counters.
//   Signal suffixes are from the fetch unit's point of view (_i into it,
//   _o out of it).
//   Modports:
//     slave  - the fetch unit itself
//     master - the surrounding pipeline / memory / predictor (or a bench)
//   CNT_W must match the CNT_W of the attached fetch_pc_unit.
interface fetch_pc_unit_if #(
  parameter int CNT_W = 16
);
  logic             stall_i;
  logic [15:0]      imem_adr_o;
  logic [15:0]      imem_rdata_i;
  logic             jump_pred_i;
  logic [15:0]      jump_pred_adr_i;
  logic             jump_pred_miss_i;
  logic             jump_pred_adr_miss_i;
  logic [15:0]      pcinc_evac_i;
  logic [15:0]      ALUres_mem_i;
  logic [15:0]      inst_id_o;
  logic [15:0]      pcinc_id_o;
  logic             valid_id_o;
  logic             flush_o;
  logic [CNT_W-1:0] cnt_pred_o;
  logic [CNT_W-1:0] cnt_miss_o;

  modport slave (
    input  stall_i, imem_rdata_i, jump_pred_i, jump_pred_adr_i,
           jump_pred_miss_i, jump_pred_adr_miss_i, pcinc_evac_i, ALUres_mem_i,
    output imem_adr_o, inst_id_o, pcinc_id_o, valid_id_o, flush_o,
           cnt_pred_o, cnt_miss_o
  );

  modport master (
    output stall_i, imem_rdata_i, jump_pred_i, jump_pred_adr_i,
           jump_pred_miss_i, jump_pred_adr_miss_i, pcinc_evac_i, ALUres_mem_i,
    input  imem_adr_o, inst_id_o, pcinc_id_o, valid_id_o, flush_o,
           cnt_pred_o, cnt_miss_o
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit
//   IF stage of the 16-bit pipeline. Owns the PC, drives the instruction
//   memory address, fills the IF/ID register and picks the next PC from the
//   jump predictor (ID-stage prediction) and MEM-stage recovery signals.
//   Ports:
//     clk    - clock
//     reset  - synchronous, active-high reset
//     bus    - fetch_pc_unit_if.slave: stall, imem address/data, predictor
//              inputs, IF/ID outputs (inst/pcinc/valid), flush, counters
//   Parameters:
//     RESET_PC - first fetch address after reset
//     CNT_W    - width of the saturating prediction / miss counters
module fetch_pc_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          CNT_W    = 16
) (
  input logic            clk,
  input logic            reset,
  fetch_pc_unit_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // pc_q: next address to issue; fetch_pc_q: address issued last cycle,
  // whose data is on imem_rdata_i now; fetch_valid_q: that data is on the
  // correct path.
  logic [15:0]      pc_q, pc_d;
  logic [15:0]      fetch_pc_q, fetch_pc_d;
  logic             fetch_valid_q, fetch_valid_d;
  logic [15:0]      inst_id_q, inst_id_d;
  logic [15:0]      pcinc_id_q, pcinc_id_d;
  logic             valid_id_q, valid_id_d;
  logic [CNT_W-1:0] cnt_pred_q, cnt_pred_d;
  logic [CNT_W-1:0] cnt_miss_q, cnt_miss_d;

  logic recover;
  assign recover = bus.jump_pred_miss_i | bus.jump_pred_adr_miss_i;

  always_comb begin
    pc_d          = pc_q;
    fetch_pc_d    = fetch_pc_q;
    fetch_valid_d = fetch_valid_q;
    inst_id_d     = inst_id_q;
    pcinc_id_d    = pcinc_id_q;
    valid_id_d    = valid_id_q;
    cnt_pred_d    = cnt_pred_q;
    cnt_miss_d    = cnt_miss_q;

    if (recover) begin
      // A wrong target beats a wrong direction when both are reported.
      pc_d          = bus.jump_pred_adr_miss_i ? bus.ALUres_mem_i : bus.pcinc_evac_i;
      fetch_valid_d = 1'b0;
      valid_id_d    = 1'b0;
      cnt_miss_d    = (cnt_miss_q == CNT_MAX) ? cnt_miss_q : cnt_miss_q + 1'b1;
    end else if (bus.jump_pred_i && !bus.stall_i) begin
      // The sequential instruction currently being fetched is wrong-path:
      // mark it invalid so it enters ID as a bubble.
      pc_d          = bus.jump_pred_adr_i;
      fetch_pc_d    = pc_q;
      fetch_valid_d = 1'b0;
      inst_id_d     = bus.imem_rdata_i;
      pcinc_id_d    = fetch_pc_q + 16'd1;
      valid_id_d    = fetch_valid_q;
      cnt_pred_d    = (cnt_pred_q == CNT_MAX) ? cnt_pred_q : cnt_pred_q + 1'b1;
    end else if (!bus.stall_i) begin
      pc_d          = pc_q + 16'd1;
      fetch_pc_d    = pc_q;
      fetch_valid_d = 1'b1;
      inst_id_d     = bus.imem_rdata_i;
      pcinc_id_d    = fetch_pc_q + 16'd1;
      valid_id_d    = fetch_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      fetch_pc_q    <= RESET_PC;
      fetch_valid_q <= 1'b0;
      inst_id_q     <= 16'h0000;
      pcinc_id_q    <= 16'h0000;
      valid_id_q    <= 1'b0;
      cnt_pred_q    <= '0;
      cnt_miss_q    <= '0;
    end else begin
      pc_q          <= pc_d;
      fetch_pc_q    <= fetch_pc_d;
      fetch_valid_q <= fetch_valid_d;
      inst_id_q     <= inst_id_d;
      pcinc_id_q    <= pcinc_id_d;
      valid_id_q    <= valid_id_d;
      cnt_pred_q    <= cnt_pred_d;
      cnt_miss_q    <= cnt_miss_d;
    end
  end

  // While stalled the memory must keep returning the pending instruction,
  // so the address already issued is presented again.
  assign bus.imem_adr_o = bus.stall_i ? fetch_pc_q : pc_q;
  assign bus.flush_o    = recover & ~reset;
  assign bus.inst_id_o  = inst_id_q;
  assign bus.pcinc_id_o = pcinc_id_q;
  assign bus.valid_id_o = valid_id_q;
  assign bus.cnt_pred_o = cnt_pred_q;
  assign bus.cnt_miss_o = cnt_miss_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit
//   Directed bench for fetch_pc_unit. Stimulus pushes the expected IF/ID
//   (inst, pcinc) pairs into a queue; a negedge monitor pops and compares
//   each newly loaded valid IF/ID entry. Cycle-specific outputs (address,
//   flush, bubbles, counters) are compared directly by the stimulus.
//   Counters use CNT_W=4 so saturation is reached in a few cycles.
module tb_fetch_pc_unit;
  localparam int CNT_W = 4;

  logic clk;
  logic reset;
  int   n_total = 0;
  int   n_pass  = 0;

  fetch_pc_unit_if #(.CNT_W(CNT_W)) bus ();

  fetch_pc_unit #(.RESET_PC(16'h0000), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: mem[a] = A000 + a, one-cycle registered read.
  always @(posedge clk) bus.imem_rdata_i <= 16'hA000 + bus.imem_adr_o;

  // Expected IF/ID stream, hand-written: {inst_id, pcinc_id}.
  logic [31:0] exp_tab [0:20] = '{
    {16'hA000, 16'h0001}, {16'hA001, 16'h0002}, {16'hA002, 16'h0003},
    {16'hA003, 16'h0004}, {16'hA004, 16'h0005}, {16'hA005, 16'h0006},
    {16'hA040, 16'h0041}, {16'hA041, 16'h0042},
    {16'hA080, 16'h0081}, {16'hA081, 16'h0082}, {16'hA082, 16'h0083},
    {16'hA011, 16'h0012}, {16'hA030, 16'h0031},
    {16'h9FFF, 16'h0000}, {16'hA000, 16'h0001}, {16'hA001, 16'h0002},
    {16'hA100, 16'h0101}, {16'hA101, 16'h0102},
    {16'hA000, 16'h0001}, {16'hA001, 16'h0002}, {16'hA002, 16'h0003}
  };
  logic [31:0] exp_q [$];

  task automatic push_exp(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) exp_q.push_back(exp_tab[i]);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
  endtask

  // Monitor: an IF/ID entry is new unless the previous cycle was a plain
  // stall (which holds IF/ID).
  logic prev_hold = 1'b0;
  always @(negedge clk) begin
    logic [31:0] e;
    if (!reset && bus.valid_id_o && !prev_hold) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL sb_unexpected: got inst %h pcinc %h, expected nothing", bus.inst_id_o, bus.pcinc_id_o);
      end else begin
        e = exp_q.pop_front();
        chk("sb_inst", bus.inst_id_o, e[31:16]);
        chk("sb_pcinc", bus.pcinc_id_o, e[15:0]);
        $display("ID inst=%h pcinc=%h", bus.inst_id_o, bus.pcinc_id_o);
      end
    end
    prev_hold <= bus.stall_i & ~bus.jump_pred_miss_i & ~bus.jump_pred_adr_miss_i & ~reset;
  end

  task automatic drive(input logic r, input logic st, input logic jp, input logic [15:0] jpa,
                       input logic pm, input logic am, input logic [15:0] ev, input logic [15:0] alu);
    @(posedge clk);
    #1;
    reset                    = r;
    bus.stall_i              = st;
    bus.jump_pred_i          = jp;
    bus.jump_pred_adr_i      = jpa;
    bus.jump_pred_miss_i     = pm;
    bus.jump_pred_adr_miss_i = am;
    bus.pcinc_evac_i         = ev;
    bus.ALUres_mem_i         = alu;
    #1;
  endtask

  task automatic seq();
    drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  initial begin
    reset                    = 1'b1;
    bus.stall_i              = 1'b0;
    bus.jump_pred_i          = 1'b0;
    bus.jump_pred_adr_i      = 16'h0;
    bus.jump_pred_miss_i     = 1'b1;
    bus.jump_pred_adr_miss_i = 1'b0;
    bus.pcinc_evac_i         = 16'h0;
    bus.ALUres_mem_i         = 16'h0;

    // T1: reset, with a miss asserted to show flush is gated by reset
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 16'h0);
    chk("rst_flush", {15'h0, bus.flush_o}, 16'h0);
    chk("rst_adr", bus.imem_adr_o, 16'h0000);
    chk("rst_valid", {15'h0, bus.valid_id_o}, 16'h0);
    chk("rst_inst", bus.inst_id_o, 16'h0000);
    chk("rst_pcinc", bus.pcinc_id_o, 16'h0000);
    chk("rst_cnt_pred", 16'(bus.cnt_pred_o), 16'h0);
    chk("rst_cnt_miss", 16'(bus.cnt_miss_o), 16'h0);

    push_exp(0, 7);
    for (int k = 0; k <= 5; k++) begin
      seq();
      chk("seq_adr", bus.imem_adr_o, 16'(k));
      if (k == 1) chk("first_valid_c1", {15'h0, bus.valid_id_o}, 16'h0);
      if (k == 2) begin
        chk("first_valid_c2", {15'h0, bus.valid_id_o}, 16'h1);
        chk("first_inst", bus.inst_id_o, 16'hA000);
        chk("first_pcinc", bus.pcinc_id_o, 16'h0001);
      end
    end

    // T2: taken prediction to 0x40 while pcinc_id = 5
    drive(1'b0, 1'b0, 1'b1, 16'h0040, 1'b0, 1'b0, 16'h0, 16'h0);
    chk("pred_pcinc", bus.pcinc_id_o, 16'h0005);
    chk("pred_adr_before", bus.imem_adr_o, 16'h0006);
    seq();
    chk("pred_adr_target", bus.imem_adr_o, 16'h0040);
    chk("pred_cnt", 16'(bus.cnt_pred_o), 16'h1);
    seq();
    chk("pred_bubble", {15'h0, bus.valid_id_o}, 16'h0);
    seq();
    chk("pred_target_id", bus.inst_id_o, 16'hA040);

    // T3: address miss to 0x80 with a simultaneous prediction
    push_exp(8, 10);
    drive(1'b0, 1'b0, 1'b1, 16'h0055, 1'b0, 1'b1, 16'h0, 16'h0080);
    chk("adrmiss_flush", {15'h0, bus.flush_o}, 16'h1);
    seq();
    chk("adrmiss_adr", bus.imem_adr_o, 16'h0080);
    chk("adrmiss_flush_off", {15'h0, bus.flush_o}, 16'h0);
    chk("adrmiss_bubble1", {15'h0, bus.valid_id_o}, 16'h0);
    chk("adrmiss_cnt_miss", 16'(bus.cnt_miss_o), 16'h1);
    chk("adrmiss_cnt_pred", 16'(bus.cnt_pred_o), 16'h1);
    seq();
    chk("adrmiss_bubble2", {15'h0, bus.valid_id_o}, 16'h0);
    seq();
    chk("adrmiss_target_id", bus.inst_id_o, 16'hA080);

    // T5: stall three cycles (prediction during stall ignored)
    drive(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    chk("stall_adr0", bus.imem_adr_o, 16'h0082);
    drive(1'b0, 1'b1, 1'b1, 16'h0077, 1'b0, 1'b0, 16'h0, 16'h0);
    chk("stall_adr1", bus.imem_adr_o, 16'h0082);
    chk("stall_inst1", bus.inst_id_o, 16'hA081);
    drive(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    chk("stall_adr2", bus.imem_adr_o, 16'h0082);
    chk("stall_inst2", bus.inst_id_o, 16'hA081);
    chk("stall_valid2", {15'h0, bus.valid_id_o}, 16'h1);
    chk("stall_cnt_pred", 16'(bus.cnt_pred_o), 16'h1);
    seq();
    chk("release_adr", bus.imem_adr_o, 16'h0083);
    chk("release_inst_held", bus.inst_id_o, 16'hA081);

    // T4: direction miss during stall; then both misses at once
    push_exp(11, 12);
    drive(1'b0, 1'b1, 1'b1, 16'h0066, 1'b1, 1'b0, 16'h0011, 16'h0);
    chk("miss_flush", {15'h0, bus.flush_o}, 16'h1);
    chk("release_inst", bus.inst_id_o, 16'hA082);
    chk("release_pcinc", bus.pcinc_id_o, 16'h0083);
    seq();
    chk("miss_adr", bus.imem_adr_o, 16'h0011);
    chk("miss_cnt", 16'(bus.cnt_miss_o), 16'h2);
    seq();
    chk("miss_bubble", {15'h0, bus.valid_id_o}, 16'h0);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0011, 16'h0030);
    chk("both_flush", {15'h0, bus.flush_o}, 16'h1);
    seq();
    chk("both_adr", bus.imem_adr_o, 16'h0030);
    chk("both_cnt", 16'(bus.cnt_miss_o), 16'h3);
    seq();

    // T6: wrap from FFFF, counter saturation, reset mid-stall
    push_exp(13, 17);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0, 16'hFFFF);
    seq();
    chk("wrap_adr_ffff", bus.imem_adr_o, 16'hFFFF);
    seq();
    chk("wrap_adr_0000", bus.imem_adr_o, 16'h0000);
    seq();
    chk("wrap_pcinc", bus.pcinc_id_o, 16'h0000);
    seq();
    for (int i = 0; i < 13; i++) begin
      drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0100, 16'h0);
      chk("sat_cnt_miss", 16'(bus.cnt_miss_o), (4 + i > 15) ? 16'd15 : 16'(4 + i));
    end
    seq();
    chk("sat_final", 16'(bus.cnt_miss_o), 16'h000F);
    chk("sat_adr", bus.imem_adr_o, 16'h0100);
    seq();
    seq();
    drive(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    chk("mid_rst_adr", bus.imem_adr_o, 16'h0000);
    chk("mid_rst_inst", bus.inst_id_o, 16'h0000);
    chk("mid_rst_pcinc", bus.pcinc_id_o, 16'h0000);
    chk("mid_rst_valid", {15'h0, bus.valid_id_o}, 16'h0);
    chk("mid_rst_cnt_pred", 16'(bus.cnt_pred_o), 16'h0);
    chk("mid_rst_cnt_miss", 16'(bus.cnt_miss_o), 16'h0);

    push_exp(18, 20);
    for (int k = 0; k <= 4; k++) begin
      seq();
      chk("restart_adr", bus.imem_adr_o, 16'(k));
    end
    @(negedge clk);
    #1;
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL sb_leftover: got %0d entries pending, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end
endmodule
